// File: rtl/muldiv_ctrl_pkg.sv
// Shared multiply/divide operation codes and small decode helpers
// used by the HI/LO controller and its datapath.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_e;

  // Signed variants carry a zero in the low opcode bit.
  function automatic logic isSignedOp(input logic [1:0] op);
    return (op[0] == 1'b0);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one shift-add (multiply) or one restoring-divide
// step per cycle on an {accHi, accLo} register pair.
module muldiv_core
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] loadA,
  input  logic [WIDTH-1:0] loadB,
  output logic [WIDTH-1:0] accHi,
  output logic [WIDTH-1:0] accLo
);

  logic [WIDTH-1:0] accHi_r;
  logic [WIDTH-1:0] accLo_r;
  logic [WIDTH-1:0] opB_r;
  logic             isDiv_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   remShift_s;
  logic             geq_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] nextHi_s;
  logic [WIDTH-1:0] nextLo_s;

  // Single-step arithmetic for both operations.
  always_comb begin
    isDiv_s    = isDivOp(op);
    sum_s      = {1'b0, accHi_r} + (accLo_r[0] ? {1'b0, opB_r} : {(WIDTH+1){1'b0}});
    remShift_s = {accHi_r, accLo_r[WIDTH-1]};
    geq_s      = (remShift_s >= {1'b0, opB_r});
    // When geq_s holds the difference is below 2^WIDTH, so the narrow subtract is exact.
    diff_s     = remShift_s[WIDTH-1:0] - opB_r;
    nextHi_s   = accHi_r;
    nextLo_s   = accLo_r;
    if (isDiv_s) begin
      if (geq_s) begin
        nextHi_s = diff_s;
        nextLo_s = {accLo_r[WIDTH-2:0], 1'b1};
      end else begin
        nextHi_s = remShift_s[WIDTH-1:0];
        nextLo_s = {accLo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi_s = sum_s[WIDTH:1];
      nextLo_s = {sum_s[0], accLo_r[WIDTH-1:1]};
    end
  end

  // Accumulator registers: load operands, then advance one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      accHi_r <= {WIDTH{1'b0}};
      accLo_r <= {WIDTH{1'b0}};
      opB_r   <= {WIDTH{1'b0}};
    end else if (load) begin
      accHi_r <= {WIDTH{1'b0}};
      accLo_r <= loadA;
      opB_r   <= loadB;
    end else if (step) begin
      accHi_r <= nextHi_s;
      accLo_r <= nextLo_s;
    end else begin
      accHi_r <= accHi_r;
      accLo_r <= accLo_r;
    end
  end

  assign accHi = accHi_r;
  assign accLo = accLo_r;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the MIPS core: sequences the iterative mul/div datapath,
// applies sign fix-up, handles MTHI/MTLO and raises the Decode stall request.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             WriteHiE,
  input  logic             WriteLoE,
  input  logic             HiLoAccessD,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             StallMD
);

  localparam int CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    FIXUP = 2'b10
  } state_e;

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic             negA_r;
  logic             negB_r;
  logic             divZero_r;
  logic [WIDTH-1:0] srcA_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;

  logic             start_s;
  logic             step_s;
  logic             signedIn_s;
  logic [WIDTH-1:0] magA_s;
  logic [WIDTH-1:0] magB_s;
  logic [WIDTH-1:0] coreHi_s;
  logic [WIDTH-1:0] coreLo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] resHi_s;
  logic [WIDTH-1:0] resLo_s;

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  always_comb begin
    signedIn_s = isSignedOp(OpE);
    start_s    = (state_r == IDLE) && StartE;
    step_s     = (state_r == BUSY);
    if (signedIn_s && SrcAE[WIDTH-1]) begin
      magA_s = -SrcAE;
    end else begin
      magA_s = SrcAE;
    end
    if (signedIn_s && SrcBE[WIDTH-1]) begin
      magB_s = -SrcBE;
    end else begin
      magB_s = SrcBE;
    end
  end

  muldiv_core #(
    .WIDTH(WIDTH)
  ) uCore (
    .clk   (clk),
    .reset (reset),
    .load  (start_s),
    .step  (step_s),
    .op    (op_r),
    .loadA (magA_s),
    .loadB (magB_s),
    .accHi (coreHi_s),
    .accLo (coreLo_s)
  );

  // Sign correction and divide-by-zero override applied to the raw magnitudes.
  always_comb begin
    prod_s  = {coreHi_s, coreLo_s};
    resHi_s = coreHi_s;
    resLo_s = coreLo_s;
    if (isDivOp(op_r)) begin
      if (divZero_r) begin
        resHi_s = srcA_r;
        resLo_s = {WIDTH{1'b1}};
      end else begin
        resLo_s = (negA_r ^ negB_r) ? -coreLo_s : coreLo_s;
        resHi_s = negA_r ? -coreHi_s : coreHi_s;
      end
    end else begin
      if (negA_r ^ negB_r) begin
        prod_s = -{coreHi_s, coreLo_s};
      end else begin
        prod_s = {coreHi_s, coreLo_s};
      end
      resHi_s = prod_s[2*WIDTH-1:WIDTH];
      resLo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration counter and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 2'b00;
      negA_r    <= 1'b0;
      negB_r    <= 1'b0;
      divZero_r <= 1'b0;
      srcA_r    <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (StartE) begin
            state_r   <= BUSY;
            busy_r    <= 1'b1;
            cnt_r     <= CNT_LOAD;
            op_r      <= OpE;
            negA_r    <= signedIn_s & SrcAE[WIDTH-1];
            negB_r    <= signedIn_s & SrcBE[WIDTH-1];
            divZero_r <= (SrcBE == {WIDTH{1'b0}});
            srcA_r    <= SrcAE;
          end else begin
            if (WriteHiE) begin
              hi_r <= SrcAE;
            end else begin
              hi_r <= hi_r;
            end
            if (WriteLoE) begin
              lo_r <= SrcAE;
            end else begin
              lo_r <= lo_r;
            end
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - CNT_LAST;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIXUP;
          end else begin
            state_r <= BUSY;
          end
        end
        FIXUP: begin
          hi_r    <= resHi_s;
          lo_r    <= resLo_s;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Hi      = hi_r;
  assign Lo      = lo_r;
  assign Busy    = busy_r;
  // Same-cycle so the hazard unit can hold Decode before it issues a HI/LO access.
  assign StallMD = busy_r & HiLoAccessD;

endmodule
